// File: rtl/resp_capture_reader_if.sv
// Output stream of the response capture reader.
// The capture block drives valid and data; the reader drives ready.
interface resp_capture_reader_if #(
   parameter int WORD = 8
) ();
   logic            out_valid;
   logic            out_ready;
   logic [WORD-1:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/resp_capture_reader.sv
// Response capture: samples dut_out, packs it LSB-first into words, and buffers them in a FIFO.
// Defining RESP_CAPTURE_SIG_EN adds a CRC-16-CCITT signature over the samples.
module resp_capture_reader #(
   parameter int WORD    = 8,
   parameter int DEPTH   = 16,
   parameter int CAP_LEN = 16
) (
   input  logic                   CK,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   sample_en,
   input  logic                   dut_out,
   resp_capture_reader_if.master  io,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
`ifdef RESP_CAPTURE_SIG_EN
   ,
   output logic [15:0]            sig
`endif
);
   localparam int BW = (WORD > 1) ? $clog2(WORD) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(CAP_LEN + 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

   state_t          state;
   logic [BW-1:0]   bit_cnt;
   logic [CW-1:0]   sample_cnt;
   logic [WORD-1:0] pack;
   logic [WORD-1:0] data_q;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [WORD-1:0] mem [DEPTH];

   logic            take;
   logic            last_bit;
   logic            last_smp;
   logic [WORD-1:0] fill;
   logic            push;
   logic            do_push;
   logic            pop;
   logic [WORD-1:0] push_word;
   logic [LW-1:0]   lvl_next;
   logic [PW-1:0]   rd_next;

   always_comb begin
      take          = (state == CAPTURE) && sample_en;
      last_bit      = bit_cnt == BW'(WORD - 1);
      last_smp      = sample_cnt == CW'(CAP_LEN - 1);
      fill          = pack;
      fill[bit_cnt] = dut_out;
      push          = (take && last_bit) || (state == FLUSH);
      push_word     = (state == FLUSH) ? pack : fill;
      pop           = (level != '0) && io.out_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle
      do_push       = push && ((level != LW'(DEPTH)) || pop);
      lvl_next      = level + LW'(do_push) - LW'(pop);
      rd_next       = pop ? rd_ptr + 1'b1 : rd_ptr;
   end

   assign io.out_valid = level != '0;
   assign io.out_data  = data_q;
   assign busy         = (state == CAPTURE) || (state == FLUSH);
   assign done         = state == DONE;

`ifdef RESP_CAPTURE_SIG_EN
   logic        fb;
   logic [15:0] crc_next;

   always_comb begin
      fb       = sig[15] ^ dut_out;
      crc_next = {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   end
`endif

   always_ff @(posedge CK) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         sample_cnt <= '0;
         pack       <= '0;
         data_q     <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
`ifdef RESP_CAPTURE_SIG_EN
         sig        <= 16'hFFFF;
`endif
      end else begin
         level <= lvl_next;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         // Head register holds its last word while the FIFO is empty
         if (lvl_next != '0)
            data_q <= (do_push && lvl_next == LW'(1)) ? push_word : mem[rd_next];
         if (push && !do_push) overflow <= 1'b1;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= CAPTURE;
                  bit_cnt    <= '0;
                  sample_cnt <= '0;
                  pack       <= '0;
                  overflow   <= 1'b0;
`ifdef RESP_CAPTURE_SIG_EN
                  sig        <= 16'hFFFF;
`endif
               end
            end
            CAPTURE: begin
               if (sample_en) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  bit_cnt    <= last_bit ? '0 : bit_cnt + 1'b1;
                  pack       <= last_bit ? '0 : fill;
`ifdef RESP_CAPTURE_SIG_EN
                  sig        <= crc_next;
`endif
                  if (last_smp) state <= last_bit ? DONE : FLUSH;
               end
            end
            FLUSH: begin
               state <= DONE;
               pack  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_resp_capture_reader.sv
// Bench for resp_capture_reader: two instances (CAP_LEN 16 and 12, DEPTH 4)
// checked every cycle against a word/queue level reference model.
module tb_resp_capture_reader;
   localparam int WORD  = 8;
   localparam int DEPTH = 4;

   logic CK = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic sample_en = 1'b0;
   logic dut_out = 1'b0;
   logic rdy = 1'b0;

   always #5 CK = ~CK;

   resp_capture_reader_if #(.WORD(WORD)) ia ();
   resp_capture_reader_if #(.WORD(WORD)) ib ();
   assign ia.out_ready = rdy;
   assign ib.out_ready = rdy;

   logic [2:0]  lva, lvb;
   logic        bza, bzb, dna, dnb, ova, ovb;
`ifdef RESP_CAPTURE_SIG_EN
   logic [15:0] sga, sgb;
`endif

   resp_capture_reader #(.WORD(WORD), .DEPTH(DEPTH), .CAP_LEN(16)) dut_a (
      .CK(CK), .reset(reset), .start(start), .sample_en(sample_en),
      .dut_out(dut_out), .io(ia.master), .level(lva), .busy(bza),
      .done(dna), .overflow(ova)
`ifdef RESP_CAPTURE_SIG_EN
      , .sig(sga)
`endif
   );

   resp_capture_reader #(.WORD(WORD), .DEPTH(DEPTH), .CAP_LEN(12)) dut_b (
      .CK(CK), .reset(reset), .start(start), .sample_en(sample_en),
      .dut_out(dut_out), .io(ib.master), .level(lvb), .busy(bzb),
      .done(dnb), .overflow(ovb)
`ifdef RESP_CAPTURE_SIG_EN
      , .sig(sgb)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state, phases: 0 idle, 1 capture, 2 flush, 3 done
   int          ph [2];
   int          n [2];
   bit          smp [2][64];
   logic [7:0]  fq [2][8];
   int          cnt [2];
   bit          ov [2];
   logic [7:0]  last [2];
   logic [15:0] sg [2];
   logic [7:0]  plog [2][64];
   int          pcnt [2];

   function automatic int caplen(int i);
      return (i == 0) ? 16 : 12;
   endfunction

   function automatic logic [15:0] crc_bit(logic [15:0] c, bit b);
      bit fb;
      fb = c[15] ^ b;
      c = c << 1;
      if (fb) c = c ^ 16'h1021;
      return c;
   endfunction

   function automatic logic [7:0] word_of(int i, int base, int k);
      logic [7:0] w;
      w = '0;
      for (int j = 0; j < k; j++) w[j] = smp[i][base + j];
      return w;
   endfunction

   task automatic mreset(int i);
      ph[i] = 0; n[i] = 0; cnt[i] = 0; ov[i] = 0;
      last[i] = '0; sg[i] = 16'hFFFF;
   endtask

   task automatic mstep(int i, bit st, bit se, bit d, bit r);
      bit pop, psh, full;
      logic [7:0] w;
      int k;
      pop = (cnt[i] > 0) && r;
      full = cnt[i] == DEPTH;
      psh = 0;
      w = '0;
      case (ph[i])
         0, 3: if (st) begin
            ph[i] = 1; n[i] = 0; ov[i] = 0; sg[i] = 16'hFFFF;
         end
         1: if (se) begin
            smp[i][n[i]] = d;
            n[i]++;
            sg[i] = crc_bit(sg[i], d);
            if (n[i] % WORD == 0) begin
               psh = 1;
               w = word_of(i, n[i] - WORD, WORD);
            end
            if (n[i] == caplen(i)) ph[i] = (n[i] % WORD == 0) ? 3 : 2;
         end
         2: begin
            k = n[i] % WORD;
            psh = 1;
            w = word_of(i, n[i] - k, k);
            ph[i] = 3;
         end
         default: ;
      endcase
      if (pop) begin
         if (pcnt[i] < 64) begin
            plog[i][pcnt[i]] = fq[i][0];
            pcnt[i]++;
         end
         for (int j = 0; j < cnt[i] - 1; j++) fq[i][j] = fq[i][j + 1];
         cnt[i]--;
      end
      if (psh) begin
         if (!full || pop) begin
            fq[i][cnt[i]] = w;
            cnt[i]++;
         end else ov[i] = 1;
      end
      if (cnt[i] > 0) last[i] = fq[i][0];
   endtask

   task automatic chk_inst(string nm, int i, logic v, logic [7:0] dt,
                           logic [2:0] lv, logic bz, logic dn, logic o);
      chk({nm, ".valid"}, v, cnt[i] > 0);
      chk({nm, ".data"}, dt, last[i]);
      chk({nm, ".level"}, lv, cnt[i]);
      chk({nm, ".busy"}, bz, ph[i] == 1 || ph[i] == 2);
      chk({nm, ".done"}, dn, ph[i] == 3);
      chk({nm, ".overflow"}, o, ov[i]);
   endtask

   task automatic check_all();
      chk_inst("a", 0, ia.out_valid, ia.out_data, lva, bza, dna, ova);
      chk_inst("b", 1, ib.out_valid, ib.out_data, lvb, bzb, dnb, ovb);
`ifdef RESP_CAPTURE_SIG_EN
      chk("a.sig", sga, sg[0]);
      chk("b.sig", sgb, sg[1]);
`endif
   endtask

   task automatic cyc(bit st, bit se, bit d, bit r);
      start = st; sample_en = se; dut_out = d; rdy = r;
      @(posedge CK);
      mstep(0, st, se, d, r);
      mstep(1, st, se, d, r);
      @(negedge CK);
      check_all();
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      start = 1'($urandom); sample_en = 1'($urandom);
      dut_out = 1'($urandom); rdy = 1'($urandom);
      #1;
      mreset(0);
      mreset(1);
      check_all();
      @(posedge CK);
      @(negedge CK);
      check_all();
      reset = 1'b1;
   endtask

   task automatic run_bits(logic [15:0] pat, int nb, bit r);
      for (int k = 0; k < nb; k++) cyc(0, 1, pat[k], r);
   endtask

   initial begin
      mreset(0);
      mreset(1);
      pcnt[0] = 0;
      pcnt[1] = 0;
      for (int k = 0; k < 3; k++) begin
         start = 1'($urandom); sample_en = 1'($urandom);
         dut_out = 1'($urandom); rdy = 1'($urandom);
         @(negedge CK);
         check_all();
      end
      reset = 1'b1;
      repeat (3) cyc(0, 1, 1, 1);

      // basic capture and partial flush
      cyc(1, 0, 0, 1);
      run_bits(16'hFF4D, 16, 1);
      repeat (3) cyc(0, 0, 0, 1);
      chk("basic.a.w0", plog[0][0], 8'h4D);
      chk("basic.a.w1", plog[0][1], 8'hFF);
      chk("basic.b.w0", plog[1][0], 8'h4D);
      chk("basic.b.w1", plog[1][1], 8'h0F);
      chk("basic.a.npop", pcnt[0], 2);
      chk("basic.a.ovf", ova, 0);

      // sample_en gaps mid-word give the same words
      pcnt[0] = 0;
      pcnt[1] = 0;
      cyc(1, 0, 0, 1);
      run_bits(16'h0005, 3, 1);
      repeat (3) cyc(0, 0, 1, 1);
      run_bits(16'h1FE9, 13, 1);
      repeat (3) cyc(0, 0, 0, 1);
      chk("gap.a.w0", plog[0][0], 8'h4D);
      chk("gap.a.w1", plog[0][1], 8'hFF);
      chk("gap.b.w1", plog[1][1], 8'h0F);

      // fill both FIFOs with out_ready low
      for (int r = 0; r < 2; r++) begin
         cyc(1, 0, 1, 0);
         run_bits(16'hFFFF, 16, 0);
      end
      chk("fill.a.level", lva, 4);
      chk("fill.a.ovf", ova, 0);
      // push and pop together while full, then a dropped word
      cyc(1, 0, 1, 0);
      for (int k = 0; k < 16; k++) begin
         cyc(0, 1, 1, k == 7);
         if (k == 7) begin
            chk("full_pp.a.level", lva, 4);
            chk("full_pp.a.ovf", ova, 0);
         end
      end
      cyc(0, 0, 0, 0);
      chk("ovf.a.set", ova, 1);
      chk("ovf.b.set", ovb, 1);
      chk("ovf.a.level", lva, 4);
      cyc(1, 0, 0, 0);
      chk("ovf.a.clear", ova, 0);
      chk("ovf.a.keep_level", lva, 4);
      chk("ovf.a.head", ia.out_data, 8'hFF);
      repeat (6) cyc(0, 0, 0, 1);

      // reset after the fifth sample
      cyc(1, 0, 0, 1);
      run_bits(16'h0015, 5, 0);
      pulse_reset();
      chk("mreset.a.level", lva, 0);
      chk("mreset.a.busy", bza, 0);
      chk("mreset.b.data", ib.out_data, 0);

      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(99) == 0) pulse_reset();
         else cyc($urandom_range(7) == 0, $urandom_range(3) != 0,
                  1'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
